// File: rtl/tgt_pyld_sched.sv
// ---------------------------------------------------------------------------
// tgt_pyld_sched
//   Round-robin scheduler in front of the target payload receive path.
//   It tracks how many packets are pending per P2P queue, based on the
//   header arrivals from the header parser. It grants one queue at a time
//   to tgt_pyld_recv_proc. When the payload-done pulse arrives, it retires
//   one packet from that queue.
//
// Configuration macro:
//   TGT_SCHED_Q0_PRIO_EN - queue 0 gets strict priority in IDLE, and granting
//                          queue 0 does not advance the round-robin pointer.
//                          When this macro is undefined, the scheduler is pure
//                          round-robin over all queues.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   sched_en   in   allow new grants (a grant already held is unaffected)
//   hdr_wen    in   one packet header arrived for hdr_qnum
//   hdr_qnum   in   queue of the arriving packet
//   pyld_done  in   granted packet fully consumed (last beat handshaked)
//   nxt_vaild  out  grant valid
//   nxt_qnum   out  granted queue, zero-extended to 8 bits
//   pend_any   out  registered OR of all pending counters != 0
//   sched_err  out  sticky: counter overflow, or pyld_done with no grant
//
// QUEUE_NUM must be a power of two (equal to 2**QUEUE_NUM_LOG), so that the
// pointer arithmetic wraps on its own.
// ---------------------------------------------------------------------------
module tgt_pyld_sched #(
   parameter int QUEUE_NUM     = 16,
   parameter int QUEUE_NUM_LOG = 4,
   parameter int CNT_W         = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sched_en,
   input  logic                     hdr_wen,
   input  logic [QUEUE_NUM_LOG-1:0] hdr_qnum,
   input  logic                     pyld_done,
   output logic                     nxt_vaild,
   output logic [7:0]               nxt_qnum,
   output logic                     pend_any,
   output logic                     sched_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'b01,
      GRANT = 2'b10
   } state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q [QUEUE_NUM];
   logic [CNT_W-1:0]         cnt_d [QUEUE_NUM];
   logic [QUEUE_NUM_LOG-1:0] rr_ptr_q, rr_ptr_d;
   logic [QUEUE_NUM_LOG-1:0] gnt_qnum_q, gnt_qnum_d;
   logic                     nxt_vaild_q, nxt_vaild_d;
   logic [7:0]               nxt_qnum_q, nxt_qnum_d;
   logic                     pend_any_q, pend_any_d;
   logic                     sched_err_q, sched_err_d;

   logic [QUEUE_NUM-1:0]     nz;
   logic                     found;
   logic [QUEUE_NUM_LOG-1:0] pick;
   logic [QUEUE_NUM_LOG-1:0] srch_idx;
   logic                     retire;

   always_comb begin
      for (int i = 0; i < QUEUE_NUM; i++) begin
         nz[i] = (cnt_q[i] != '0);
      end
   end

   // Rotate-and-priority-encode in a single cycle. The scan starts at rr_ptr
   // and wraps modulo QUEUE_NUM. The first nonzero queue it finds wins.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      srch_idx = '0;
      for (int i = 0; i < QUEUE_NUM; i++) begin
         srch_idx = rr_ptr_q + QUEUE_NUM_LOG'(i);
         if (!found && nz[srch_idx]) begin
            found = 1'b1;
            pick  = srch_idx;
         end
      end
`ifdef TGT_SCHED_Q0_PRIO_EN
      if (nz[0]) begin
         pick = '0;
      end
`endif
   end

   assign retire = (state_q == GRANT) && pyld_done;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_qnum_d  = gnt_qnum_q;
      nxt_vaild_d = nxt_vaild_q;
      nxt_qnum_d  = nxt_qnum_q;
      sched_err_d = sched_err_q;
      pend_any_d  = |nz;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            if (sched_en && found) begin
               state_d     = GRANT;
               gnt_qnum_d  = pick;
               nxt_vaild_d = 1'b1;
               nxt_qnum_d  = {{(8-QUEUE_NUM_LOG){1'b0}}, pick};
            end
         end
         GRANT: begin
            // sched_en is deliberately ignored here. A held grant stays
            // until its payload completes.
            if (pyld_done) begin
               state_d     = IDLE;
               nxt_vaild_d = 1'b0;
`ifdef TGT_SCHED_Q0_PRIO_EN
               if (gnt_qnum_q != '0) begin
                  rr_ptr_d = gnt_qnum_q + 1'b1;
               end
`else
               rr_ptr_d = gnt_qnum_q + 1'b1;
`endif
            end
         end
         default: begin
            state_d     = IDLE;
            nxt_vaild_d = 1'b0;
         end
      endcase

      if (pyld_done && (state_q != GRANT)) begin
         sched_err_d = 1'b1;
      end

      // When an increment and a retire hit the same queue in one cycle,
      // they cancel. The retire cannot underflow, because a grant is only
      // issued for a nonzero counter.
      for (int i = 0; i < QUEUE_NUM; i++) begin
         if ((hdr_wen && (hdr_qnum == QUEUE_NUM_LOG'(i))) &&
             !(retire && (gnt_qnum_q == QUEUE_NUM_LOG'(i)))) begin
            if (cnt_q[i] == {CNT_W{1'b1}}) begin
               sched_err_d = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else if (!(hdr_wen && (hdr_qnum == QUEUE_NUM_LOG'(i))) &&
                      (retire && (gnt_qnum_q == QUEUE_NUM_LOG'(i)))) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gnt_qnum_q  <= '0;
         nxt_vaild_q <= 1'b0;
         nxt_qnum_q  <= '0;
         pend_any_q  <= 1'b0;
         sched_err_q <= 1'b0;
         for (int i = 0; i < QUEUE_NUM; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_qnum_q  <= gnt_qnum_d;
         nxt_vaild_q <= nxt_vaild_d;
         nxt_qnum_q  <= nxt_qnum_d;
         pend_any_q  <= pend_any_d;
         sched_err_q <= sched_err_d;
         for (int i = 0; i < QUEUE_NUM; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign nxt_vaild = nxt_vaild_q;
   assign nxt_qnum  = nxt_qnum_q;
   assign pend_any  = pend_any_q;
   assign sched_err = sched_err_q;

endmodule

// File: tb/tb_tgt_pyld_sched.sv
// ---------------------------------------------------------------------------
// tb_tgt_pyld_sched
//   Bench for tgt_pyld_sched. Directed scenarios use fixed expected values.
//   A random phase compares the DUT against a queue-count reference model
//   that advances alongside the DUT every clock.
// ---------------------------------------------------------------------------
module tb_tgt_pyld_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       sched_en;
   logic       hdr_wen;
   logic [3:0] hdr_qnum;
   logic       pyld_done;
   logic       nxt_vaild;
   logic [7:0] nxt_qnum;
   logic       pend_any;
   logic       sched_err;

   int checks   = 0;
   int failures = 0;

`ifdef TGT_SCHED_Q0_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   tgt_pyld_sched dut (
      .clk       (clk),
      .rst       (rst),
      .sched_en  (sched_en),
      .hdr_wen   (hdr_wen),
      .hdr_qnum  (hdr_qnum),
      .pyld_done (pyld_done),
      .nxt_vaild (nxt_vaild),
      .nxt_qnum  (nxt_qnum),
      .pend_any  (pend_any),
      .sched_err (sched_err)
   );

   always #5 clk = ~clk;

   // Reference model: pending packets per queue, plus the grant bookkeeping.
   int m_cnt [16];
   int m_rr;
   bit m_busy;
   int m_gq;
   bit m_vld;
   int m_qnum;
   bit m_pend;
   bit m_err;

   // Advance one clock. The model's next state comes from the inputs as
   // they stand at the edge. Outputs are then sampled 1 time unit later.
   task automatic cycle();
      int n_cnt [16];
      int n_rr, n_gq, n_qnum, pk;
      bit n_busy, n_vld, n_pend, n_err, any;
      n_cnt = m_cnt; n_rr = m_rr; n_gq = m_gq; n_qnum = m_qnum;
      n_busy = m_busy; n_vld = m_vld; n_err = m_err;
      any = 1'b0;
      foreach (m_cnt[i]) if (m_cnt[i] != 0) any = 1'b1;
      n_pend = any;
      if (rst) begin
         foreach (n_cnt[i]) n_cnt[i] = 0;
         n_rr = 0; n_gq = 0; n_qnum = 0; n_busy = 0; n_vld = 0;
         n_pend = 0; n_err = 0;
      end else begin
         if (m_busy && pyld_done) n_cnt[m_gq] = n_cnt[m_gq] - 1;
         if (hdr_wen) begin
            if (m_busy && pyld_done && m_gq == int'(hdr_qnum))
               n_cnt[hdr_qnum] = n_cnt[hdr_qnum] + 1;
            else if (m_cnt[hdr_qnum] == 255)
               n_err = 1'b1;
            else
               n_cnt[hdr_qnum] = n_cnt[hdr_qnum] + 1;
         end
         if (pyld_done && !m_busy) n_err = 1'b1;
         if (m_busy) begin
            if (pyld_done) begin
               n_busy = 0; n_vld = 0;
               if (!(PRIO && m_gq == 0)) n_rr = (m_gq + 1) % 16;
            end
         end else if (sched_en && any) begin
            pk = -1;
            if (PRIO && m_cnt[0] != 0) pk = 0;
            for (int i = 0; i < 16; i++)
               if (pk < 0 && m_cnt[(m_rr + i) % 16] != 0) pk = (m_rr + i) % 16;
            n_busy = 1; n_vld = 1; n_gq = pk; n_qnum = pk;
         end
      end
      @(posedge clk);
      #1;
      m_cnt = n_cnt; m_rr = n_rr; m_gq = n_gq; m_qnum = n_qnum;
      m_busy = n_busy; m_vld = n_vld; m_pend = n_pend; m_err = n_err;
   endtask

   task automatic do_reset();
      rst = 1'b1; sched_en = 1'b0; hdr_wen = 1'b0; hdr_qnum = '0; pyld_done = 1'b0;
      cycle();
      rst = 1'b0;
   endtask

   task automatic hdr(input int q);
      hdr_wen = 1'b1; hdr_qnum = 4'(q);
      cycle();
      hdr_wen = 1'b0;
   endtask

   task automatic retire_pkt();
      pyld_done = 1'b1;
      cycle();
      pyld_done = 1'b0;
   endtask

   task automatic wait_grant(output int q, output bit ok);
      ok = 1'b0; q = -1;
      for (int i = 0; i < 40; i++) begin
         if (nxt_vaild) begin
            ok = 1'b1; q = int'(nxt_qnum);
            return;
         end
         cycle();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; sched_en = 1'b1; hdr_wen = 1'b1; hdr_qnum = 4'd2; pyld_done = 1'b0;
      cycle(); cycle();
      rst = 1'b0; hdr_wen = 1'b0; sched_en = 1'b0;
      checks++;
      if ({nxt_vaild, nxt_qnum, pend_any, sched_err} !== 11'd0) begin
         failures++;
         $display("FAIL reset_outputs got vld=%0b q=%0d pend=%0b err=%0b want all 0",
                  nxt_vaild, nxt_qnum, pend_any, sched_err);
      end
   endtask

   task automatic test_single();
      do_reset();
      sched_en = 1'b1;
      hdr(3);
      checks++;
      if (nxt_vaild !== 1'b0 || pend_any !== 1'b0) begin
         failures++;
         $display("FAIL single_t1 got vld=%0b pend=%0b want 0 0", nxt_vaild, pend_any);
      end
      cycle();
      checks++;
      if (nxt_vaild !== 1'b1 || nxt_qnum !== 8'd3 || pend_any !== 1'b1) begin
         failures++;
         $display("FAIL single_t2 got vld=%0b q=%0d pend=%0b want 1 3 1", nxt_vaild, nxt_qnum, pend_any);
      end
      sched_en = 1'b0;
      cycle(); cycle();
      checks++;
      if (nxt_vaild !== 1'b1 || nxt_qnum !== 8'd3) begin
         failures++;
         $display("FAIL single_hold got vld=%0b q=%0d want 1 3", nxt_vaild, nxt_qnum);
      end
      sched_en = 1'b1;
      retire_pkt();
      checks++;
      if (nxt_vaild !== 1'b0) begin
         failures++;
         $display("FAIL single_drop got vld=%0b want 0", nxt_vaild);
      end
      cycle();
      checks++;
      if (nxt_vaild !== 1'b0 || pend_any !== 1'b0 || sched_err !== 1'b0) begin
         failures++;
         $display("FAIL single_empty got vld=%0b pend=%0b err=%0b want 0 0 0", nxt_vaild, pend_any, sched_err);
      end
   endtask

   task automatic test_rr_fairness();
      int exp_q [3] = '{1, 5, 9};
      int q; bit ok;
      do_reset();
      for (int r = 0; r < 2; r++) for (int k = 0; k < 3; k++) hdr(exp_q[k]);
      sched_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_grant(q, ok);
         checks++;
         if (!ok || q != exp_q[k % 3]) begin
            failures++;
            $display("FAIL rr_order[%0d] got q=%0d ok=%0b want %0d", k, q, ok, exp_q[k % 3]);
         end
         retire_pkt();
         checks++;
         if (nxt_vaild !== 1'b0) begin
            failures++;
            $display("FAIL rr_bubble[%0d] got vld=%0b want 0", k, nxt_vaild);
         end
      end
   endtask

   task automatic test_wrap();
      int exp_q [3] = '{14, 15, 2};
      int q; bit ok;
      do_reset();
      hdr(14);
      sched_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_grant(q, ok);
         checks++;
         if (!ok || q != exp_q[k]) begin
            failures++;
            $display("FAIL wrap_order[%0d] got q=%0d ok=%0b want %0d", k, q, ok, exp_q[k]);
         end
         if (k == 0) begin
            hdr(15);
            hdr(2);
         end
         retire_pkt();
      end
   endtask

   task automatic test_simultaneous();
      int q; bit ok;
      do_reset();
      sched_en = 1'b1;
      hdr(7);
      wait_grant(q, ok);
      hdr_wen = 1'b1; hdr_qnum = 4'd7; pyld_done = 1'b1;
      cycle();
      hdr_wen = 1'b0; pyld_done = 1'b0;
      checks++;
      if (nxt_vaild !== 1'b0) begin
         failures++;
         $display("FAIL simul_bubble got vld=%0b want 0", nxt_vaild);
      end
      cycle();
      checks++;
      if (nxt_vaild !== 1'b1 || nxt_qnum !== 8'd7) begin
         failures++;
         $display("FAIL simul_regrant got vld=%0b q=%0d want 1 7", nxt_vaild, nxt_qnum);
      end
      retire_pkt();
      cycle();
      checks++;
      if (pend_any !== 1'b0 || nxt_vaild !== 1'b0) begin
         failures++;
         $display("FAIL simul_drained got pend=%0b vld=%0b want 0 0", pend_any, nxt_vaild);
      end
   endtask

   task automatic test_errors();
      int q, n; bit ok;
      do_reset();
      pyld_done = 1'b1;
      cycle();
      pyld_done = 1'b0;
      checks++;
      if (sched_err !== 1'b1) begin
         failures++;
         $display("FAIL err_idle_done got err=%0b want 1", sched_err);
      end
      do_reset();
      checks++;
      if (sched_err !== 1'b0 || nxt_vaild !== 1'b0 || pend_any !== 1'b0) begin
         failures++;
         $display("FAIL err_reset got err=%0b vld=%0b pend=%0b want 0 0 0", sched_err, nxt_vaild, pend_any);
      end
      for (int i = 0; i < 255; i++) hdr(0);
      checks++;
      if (sched_err !== 1'b0) begin
         failures++;
         $display("FAIL err_255 got err=%0b want 0", sched_err);
      end
      hdr(0);
      checks++;
      if (sched_err !== 1'b1) begin
         failures++;
         $display("FAIL err_overflow got err=%0b want 1", sched_err);
      end
      // A saturated counter holds 255 packets, so exactly 255 grants must drain it.
      sched_en = 1'b1;
      n = 0;
      for (int i = 0; i < 255; i++) begin
         wait_grant(q, ok);
         if (ok && q == 0) n++;
         retire_pkt();
      end
      cycle(); cycle();
      checks++;
      if (n != 255 || pend_any !== 1'b0 || nxt_vaild !== 1'b0) begin
         failures++;
         $display("FAIL err_saturated_drain got grants=%0d pend=%0b vld=%0b want 255 0 0", n, pend_any, nxt_vaild);
      end
   endtask

   task automatic test_q0_prio();
      int exp_q [3];
      int q; bit ok;
      if (PRIO) exp_q = '{0, 4, 6}; else exp_q = '{4, 6, 0};
      do_reset();
      sched_en = 1'b1;
      hdr(3);
      wait_grant(q, ok);
      sched_en = 1'b0;
      retire_pkt();
      hdr(0); hdr(4); hdr(6);
      sched_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_grant(q, ok);
         checks++;
         if (!ok || q != exp_q[k]) begin
            failures++;
            $display("FAIL prio_order[%0d] got q=%0d ok=%0b want %0d", k, q, ok, exp_q[k]);
         end
         retire_pkt();
      end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 499) == 0);
         sched_en  = ($urandom_range(0, 3) != 0);
         hdr_wen   = ($urandom_range(0, 2) == 0);
         hdr_qnum  = 4'($urandom_range(0, 15));
         pyld_done = nxt_vaild ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 149) == 0);
         cycle();
         checks++;
         if (nxt_vaild !== m_vld || pend_any !== m_pend || sched_err !== m_err ||
             (m_vld && nxt_qnum !== 8'(m_qnum))) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d] got vld=%0b q=%0d pend=%0b err=%0b want %0b %0d %0b %0b",
                        c, nxt_vaild, nxt_qnum, pend_any, sched_err, m_vld, m_qnum, m_pend, m_err);
         end
      end
      rst = 1'b0; pyld_done = 1'b0; hdr_wen = 1'b0;
   endtask

   initial begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_rr = 0; m_busy = 0; m_gq = 0; m_vld = 0; m_qnum = 0; m_pend = 0; m_err = 0;
      test_reset();
      test_single();
      test_rr_fairness();
      test_wrap();
      test_simultaneous();
      test_errors();
      test_q0_prio();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
